// File: rtl/jtbubl_snd_comm.sv
// jtbubl_snd_comm
// Mailbox between the main CPU and the sound CPU. The main CPU posts a
// command byte that the sound CPU collects; the sound CPU posts a reply
// byte that the main CPU collects. Each direction has a pending flag,
// and the sound CPU can be interrupted through an active-low NMI while a
// command is waiting, if it has enabled that.
//
// Ports
//   clk24      system clock, all logic on its rising edge
//   rst        global synchronous reset, active-high
//   snd_rst    sound-CPU reset driven by the main CPU, synchronous, active-high
//   main_cs    main CPU access window
//   main_rnw   main CPU direction, 1 = read
//   main_addr  main CPU register select
//   main_dout  main CPU write data
//   main_din   registered read data returned to the main CPU
//   snd_cs     sound CPU access window
//   snd_rnw    sound CPU direction, 1 = read
//   snd_addr   sound CPU register select
//   snd_dout   sound CPU write data
//   snd_din    registered read data returned to the sound CPU
//   snd_nmi_n  NMI to the sound CPU, active-low, registered
//
// Register map (both sides)
//   0  read: the other side's latch; write: this side's latch + set flag
//   1  read: {6'b0, rep_pend, cmd_pend}; sound write sets nmi_en
//   2  read: 8'hFF; sound write clears nmi_en
//   3  read: 8'hFF; writes ignored
module jtbubl_snd_comm (
  input  logic       clk24,
  input  logic       rst,
  input  logic       snd_rst,
  input  logic       main_cs,
  input  logic       main_rnw,
  input  logic [1:0] main_addr,
  input  logic [7:0] main_dout,
  output logic [7:0] main_din,
  input  logic       snd_cs,
  input  logic       snd_rnw,
  input  logic [1:0] snd_addr,
  input  logic [7:0] snd_dout,
  output logic [7:0] snd_din,
  output logic       snd_nmi_n
);

  logic [7:0] cmdLatch_q, cmdLatch_d;
  logic [7:0] repLatch_q, repLatch_d;
  logic       cmdPend_q, cmdPend_d;
  logic       repPend_q, repPend_d;
  logic       nmiEn_q, nmiEn_d;
  logic [7:0] mainDin_q, mainDin_d;
  logic [7:0] sndDin_q, sndDin_d;
  logic       sndNmiN_q, sndNmiN_d;

  // Previous-cycle value of each decoded access term, for edge detection
  logic mainWrLast_q, mainWrLast_d;
  logic mainRdLast_q, mainRdLast_d;
  logic sndWrLast_q, sndWrLast_d;
  logic sndRdLast_q, sndRdLast_d;

  logic mainWrTerm, mainRdTerm, sndWrTerm, sndRdTerm;
  logic mainWrEv, mainRdEv, sndWrEv, sndRdEv;

  // Access terms and their one-shot events. A chip select held for many
  // cycles produces a single event on its first cycle. While the sound
  // CPU is held in reset its accesses produce no events at all, and its
  // edge history stays cleared so an access in progress at release is
  // seen as new.
  always_comb begin
    mainWrTerm = main_cs & ~main_rnw;
    mainRdTerm = main_cs &  main_rnw;
    sndWrTerm  = snd_cs  & ~snd_rnw;
    sndRdTerm  = snd_cs  &  snd_rnw;

    mainWrEv = mainWrTerm & ~mainWrLast_q;
    mainRdEv = mainRdTerm & ~mainRdLast_q;
    sndWrEv  = sndWrTerm  & ~sndWrLast_q & ~snd_rst;
    sndRdEv  = sndRdTerm  & ~sndRdLast_q & ~snd_rst;

    mainWrLast_d = mainWrTerm;
    mainRdLast_d = mainRdTerm;
    sndWrLast_d  = sndWrTerm & ~snd_rst;
    sndRdLast_d  = sndRdTerm & ~snd_rst;
  end

  // Latches and flags. Setting a pending flag wins over clearing it in
  // the same cycle, so a new command arriving as the previous one is
  // collected is never lost. A write while the flag is already set just
  // overwrites the latch.
  always_comb begin
    cmdLatch_d = cmdLatch_q;
    repLatch_d = repLatch_q;
    cmdPend_d  = cmdPend_q;
    repPend_d  = repPend_q;
    nmiEn_d    = nmiEn_q;

    if (mainWrEv && main_addr == 2'd0) begin
      cmdLatch_d = main_dout;
      cmdPend_d  = 1'b1;
    end else if (sndRdEv && snd_addr == 2'd0) begin
      cmdPend_d  = 1'b0;
    end

    if (sndWrEv && snd_addr == 2'd0) begin
      repLatch_d = snd_dout;
      repPend_d  = 1'b1;
    end else if (mainRdEv && main_addr == 2'd0) begin
      repPend_d  = 1'b0;
    end

    if (sndWrEv && snd_addr == 2'd1) begin
      nmiEn_d = 1'b1;
    end else if (sndWrEv && snd_addr == 2'd2) begin
      nmiEn_d = 1'b0;
    end

    if (snd_rst) begin
      repPend_d = 1'b0;
      nmiEn_d   = 1'b0;
    end
  end

  // Read data is refreshed every cycle from the current register values,
  // so a status read sees the state from before any flag change taking
  // effect on the same edge.
  always_comb begin
    mainDin_d = 8'hFF;
    if (main_cs && main_rnw) begin
      case (main_addr)
        2'd0:    mainDin_d = repLatch_q;
        2'd1:    mainDin_d = {6'b0, repPend_q, cmdPend_q};
        default: mainDin_d = 8'hFF;
      endcase
    end

    sndDin_d = 8'hFF;
    if (snd_cs && snd_rnw && !snd_rst) begin
      case (snd_addr)
        2'd0:    sndDin_d = cmdLatch_q;
        2'd1:    sndDin_d = {6'b0, repPend_q, cmdPend_q};
        default: sndDin_d = 8'hFF;
      endcase
    end

    sndNmiN_d = ~(cmdPend_q & nmiEn_q & ~snd_rst);
  end

  // State registers; the global reset overrides everything else
  always_ff @(posedge clk24) begin
    if (rst) begin
      cmdLatch_q   <= 8'h00;
      repLatch_q   <= 8'h00;
      cmdPend_q    <= 1'b0;
      repPend_q    <= 1'b0;
      nmiEn_q      <= 1'b0;
      mainDin_q    <= 8'hFF;
      sndDin_q     <= 8'hFF;
      sndNmiN_q    <= 1'b1;
      mainWrLast_q <= 1'b0;
      mainRdLast_q <= 1'b0;
      sndWrLast_q  <= 1'b0;
      sndRdLast_q  <= 1'b0;
    end else begin
      cmdLatch_q   <= cmdLatch_d;
      repLatch_q   <= repLatch_d;
      cmdPend_q    <= cmdPend_d;
      repPend_q    <= repPend_d;
      nmiEn_q      <= nmiEn_d;
      mainDin_q    <= mainDin_d;
      sndDin_q     <= sndDin_d;
      sndNmiN_q    <= sndNmiN_d;
      mainWrLast_q <= mainWrLast_d;
      mainRdLast_q <= mainRdLast_d;
      sndWrLast_q  <= sndWrLast_d;
      sndRdLast_q  <= sndRdLast_d;
    end
  end

  assign main_din  = mainDin_q;
  assign snd_din   = sndDin_q;
  assign snd_nmi_n = sndNmiN_q;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// tb_jtbubl_snd_comm
// Self-checking bench for the main/sound mailbox. Expected read data is
// queued when a read is launched and compared when the registered read
// data appears. Inputs change and outputs are sampled on the falling edge.
module tb_jtbubl_snd_comm;

  logic       clk24 = 1'b0;
  logic       rst = 1'b1;
  logic       snd_rst = 1'b0;
  logic       main_cs = 1'b0;
  logic       main_rnw = 1'b1;
  logic [1:0] main_addr = 2'd0;
  logic [7:0] main_dout = 8'h00;
  logic [7:0] main_din;
  logic       snd_cs = 1'b0;
  logic       snd_rnw = 1'b1;
  logic [1:0] snd_addr = 2'd0;
  logic [7:0] snd_dout = 8'h00;
  logic [7:0] snd_din;
  logic       snd_nmi_n;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } expect_t;

  expect_t sbQueue[$];

  jtbubl_snd_comm dut (
    .clk24     (clk24),
    .rst       (rst),
    .snd_rst   (snd_rst),
    .main_cs   (main_cs),
    .main_rnw  (main_rnw),
    .main_addr (main_addr),
    .main_dout (main_dout),
    .main_din  (main_din),
    .snd_cs    (snd_cs),
    .snd_rnw   (snd_rnw),
    .snd_addr  (snd_addr),
    .snd_dout  (snd_dout),
    .snd_din   (snd_din),
    .snd_nmi_n (snd_nmi_n)
  );

  always #5 clk24 = ~clk24;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [7:0] exp);
    expect_t e;
    e.tag = tag;
    e.exp = exp;
    sbQueue.push_back(e);
  endtask

  task automatic popCheck(input logic [7:0] observed);
    expect_t e;
    if (sbQueue.size() == 0) begin
      checkOutput("sbEmpty", observed, ~observed);
    end else begin
      e = sbQueue.pop_front();
      checkOutput(e.tag, observed, e.exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk24);
  endtask

  task automatic mainWrite(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk24);
    main_cs = 1'b1; main_rnw = 1'b0; main_addr = addr; main_dout = data;
    @(negedge clk24);
    main_cs = 1'b0; main_rnw = 1'b1;
  endtask

  task automatic sndWrite(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk24);
    snd_cs = 1'b1; snd_rnw = 1'b0; snd_addr = addr; snd_dout = data;
    @(negedge clk24);
    snd_cs = 1'b0; snd_rnw = 1'b1;
  endtask

  task automatic mainRead(input logic [1:0] addr, input logic [7:0] exp,
                          input string tag);
    @(negedge clk24);
    main_cs = 1'b1; main_rnw = 1'b1; main_addr = addr;
    pushExpect(tag, exp);
    @(negedge clk24);
    popCheck(main_din);
    main_cs = 1'b0;
  endtask

  task automatic sndRead(input logic [1:0] addr, input logic [7:0] exp,
                         input string tag);
    @(negedge clk24);
    snd_cs = 1'b1; snd_rnw = 1'b1; snd_addr = addr;
    pushExpect(tag, exp);
    @(negedge clk24);
    popCheck(snd_din);
    snd_cs = 1'b0;
  endtask

  task automatic applyStimulus;
    // Reset state
    idle(3);
    checkOutput("rstMainDin", main_din, 8'hFF);
    checkOutput("rstSndDin", snd_din, 8'hFF);
    checkOutput("rstNmi", {7'b0, snd_nmi_n}, 8'h01);
    @(negedge clk24);
    rst = 1'b0;
    idle(1);
    mainRead(2'd1, 8'h00, "rstStatus");
    sndRead(2'd0, 8'h00, "rstCmdLatch");

    // Command with NMI enabled, main cs held for 20 cycles
    sndWrite(2'd1, 8'h00);
    @(negedge clk24);
    main_cs = 1'b1; main_rnw = 1'b0; main_addr = 2'd0; main_dout = 8'h5A;
    @(negedge clk24);
    checkOutput("nmiNotYet", {7'b0, snd_nmi_n}, 8'h01);
    @(negedge clk24);
    checkOutput("nmiLow", {7'b0, snd_nmi_n}, 8'h00);
    idle(3);
    snd_cs = 1'b1; snd_rnw = 1'b1; snd_addr = 2'd0;
    pushExpect("sndReadCmd5A", 8'h5A);
    @(negedge clk24);
    popCheck(snd_din);
    checkOutput("nmiStillLow", {7'b0, snd_nmi_n}, 8'h00);
    @(negedge clk24);
    checkOutput("nmiHighAfterRead", {7'b0, snd_nmi_n}, 8'h01);
    snd_cs = 1'b0;
    idle(13);
    main_cs = 1'b0; main_rnw = 1'b1;
    mainRead(2'd1, 8'h00, "cmdPendOnce");

    // Reply path
    sndWrite(2'd0, 8'hC3);
    mainRead(2'd1, 8'h02, "repPendSet");
    mainRead(2'd0, 8'hC3, "replyC3");
    mainRead(2'd1, 8'h00, "repPendClr");

    // New command coinciding with the sound CPU collecting the old one
    mainWrite(2'd0, 8'h44);
    @(negedge clk24);
    main_cs = 1'b1; main_rnw = 1'b0; main_addr = 2'd0; main_dout = 8'h11;
    snd_cs = 1'b1; snd_rnw = 1'b1; snd_addr = 2'd0;
    pushExpect("collideOldCmd", 8'h44);
    @(negedge clk24);
    popCheck(snd_din);
    main_cs = 1'b0; main_rnw = 1'b1; snd_cs = 1'b0;
    mainRead(2'd1, 8'h01, "collideSetWins");
    sndRead(2'd0, 8'h11, "collideNewCmd");
    mainRead(2'd1, 8'h00, "collideCleared");

    // NMI enable/disable
    sndWrite(2'd2, 8'h00);
    mainWrite(2'd0, 8'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk24);
      checkOutput("nmiDisabled", {7'b0, snd_nmi_n}, 8'h01);
    end
    @(negedge clk24);
    snd_cs = 1'b1; snd_rnw = 1'b0; snd_addr = 2'd1;
    @(negedge clk24);
    checkOutput("nmiEnLatency", {7'b0, snd_nmi_n}, 8'h01);
    snd_cs = 1'b0; snd_rnw = 1'b1;
    @(negedge clk24);
    checkOutput("nmiEnLow", {7'b0, snd_nmi_n}, 8'h00);
    snd_cs = 1'b1; snd_rnw = 1'b0; snd_addr = 2'd2;
    @(negedge clk24);
    checkOutput("nmiDisLatency", {7'b0, snd_nmi_n}, 8'h00);
    snd_cs = 1'b0; snd_rnw = 1'b1;
    @(negedge clk24);
    checkOutput("nmiDisHigh", {7'b0, snd_nmi_n}, 8'h01);

    // Sound CPU reset with both flags pending and NMI enabled
    sndWrite(2'd1, 8'h00);
    sndWrite(2'd0, 8'h77);
    mainRead(2'd1, 8'h03, "preSndRstStatus");
    checkOutput("preSndRstNmi", {7'b0, snd_nmi_n}, 8'h00);
    @(negedge clk24);
    snd_rst = 1'b1;
    snd_cs = 1'b1; snd_rnw = 1'b1; snd_addr = 2'd0;
    @(negedge clk24);
    checkOutput("sndRstNmi", {7'b0, snd_nmi_n}, 8'h01);
    checkOutput("sndRstDin", snd_din, 8'hFF);
    idle(2);
    snd_rst = 1'b0; snd_cs = 1'b0;
    idle(2);
    checkOutput("postSndRstNmi", {7'b0, snd_nmi_n}, 8'h01);
    mainRead(2'd1, 8'h01, "postSndRstStatus");
    mainRead(2'd0, 8'h77, "replyKept");
    sndRead(2'd0, 8'h22, "cmdKept");

    // Unmapped reads, idle bus and ignored writes
    mainRead(2'd2, 8'hFF, "mainAddr2");
    mainRead(2'd3, 8'hFF, "mainAddr3");
    sndRead(2'd2, 8'hFF, "sndAddr2");
    sndRead(2'd3, 8'hFF, "sndAddr3");
    idle(1);
    checkOutput("mainIdle", main_din, 8'hFF);
    checkOutput("sndIdle", snd_din, 8'hFF);
    mainWrite(2'd3, 8'hAB);
    sndWrite(2'd3, 8'hCD);
    mainWrite(2'd1, 8'hEE);
    mainWrite(2'd2, 8'hEE);
    mainRead(2'd1, 8'h00, "ignoredWrStatus");
    sndRead(2'd1, 8'h00, "ignoredWrSndStatus");
    mainRead(2'd0, 8'h77, "ignoredWrReply");
    sndRead(2'd0, 8'h22, "ignoredWrCmd");
    checkOutput("ignoredWrNmi", {7'b0, snd_nmi_n}, 8'h01);

    // Global reset clears the latches and flags
    mainWrite(2'd0, 8'h99);
    sndWrite(2'd0, 8'h66);
    @(negedge clk24);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    mainRead(2'd1, 8'h00, "rstClrStatus");
    sndRead(2'd0, 8'h00, "rstClrCmd");
    mainRead(2'd0, 8'h00, "rstClrReply");
  endtask

  initial begin
    applyStimulus();
    idle(2);
    if (sbQueue.size() != 0) checkOutput("sbLeftover", 8'(sbQueue.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/jtbubl_snd_comm.md
JTBUBL_SND_COMM -- requirements
Module: jtbubl_snd_comm

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port clk24  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port snd_rst  in  1  sound-CPU reset from main CPU, synchronous, active-high.
REQ-005 SHALL have port main_cs  in  1  main CPU access window to the comm block.
REQ-006 SHALL have port main_rnw  in  1  main CPU: 1 = read, 0 = write.
REQ-007 SHALL have port main_addr  in  2  main CPU register select.
REQ-008 SHALL have port main_dout  in  8  main CPU write data.
REQ-009 SHALL have port main_din  out  8  registered read data to main CPU.
REQ-010 SHALL have port snd_cs  in  1  sound CPU access window.
REQ-011 SHALL have port snd_rnw  in  1  sound CPU: 1 = read, 0 = write.
REQ-012 SHALL have port snd_addr  in  2  sound CPU register select.
REQ-013 SHALL have port snd_dout  in  8  sound CPU write data.
REQ-014 SHALL have port snd_din  out  8  registered read data to sound CPU.
REQ-015 SHALL have port snd_nmi_n  out  1  NMI to sound CPU, active-low.

Function
REQ-016 SHALL hold state: cmd latch (main->sound, 8b), reply latch (sound->main, 8b), cmd_pend, rep_pend, nmi_en.
REQ-017 SHALL define an event as the rising edge (previous cycle 0, current 1) of the decoded access term; a cs held any number of cycles yields exactly one event.
REQ-018 SHALL on main write event, addr 0: load cmd latch from main_dout; set cmd_pend.
REQ-019 SHALL on main read event, addr 0: clear rep_pend.
REQ-020 SHALL on sound write event, addr 0: load reply latch from snd_dout; set rep_pend.
REQ-021 SHALL on sound read event, addr 0: clear cmd_pend.
REQ-022 SHALL on sound write event, addr 1: set nmi_en; addr 2: clear nmi_en; data ignored.
REQ-023 SHALL ignore writes to addr 3 (either side) and main writes to addr 1-2.
REQ-024 SHALL drive main_din / snd_din, registered every cycle while cs high with rnw=1: addr 0 -> reply latch (main) / cmd latch (sound); addr 1 -> {6'b0, rep_pend, cmd_pend}; addr 2-3 -> 8'hFF; 8'hFF when cs low.
REQ-025 SHALL make read data valid one clk24 cycle after the access term is first asserted.
REQ-026 SHALL drive snd_nmi_n registered: 0 when cmd_pend & nmi_en & !snd_rst, else 1; one-cycle latency from flag change.
REQ-027 SHALL give set priority on simultaneous set and clear of the same pending flag (flag ends 1, latch holds new data).
REQ-028 SHALL, on a write event while the flag is already set, overwrite the latch and keep the flag set (no queueing).
REQ-029 SHALL update status-read data in the same cycle as a concurrent flag change takes effect in the registers (status reflects state before the edge).

Reset
REQ-030 SHALL on rst: latches 8'h00, cmd_pend 0, rep_pend 0, nmi_en 0, snd_nmi_n 1, main_din 8'hFF, snd_din 8'hFF, edge history 0.
REQ-031 SHALL on snd_rst (rst low): clear nmi_en, rep_pend, sound-side edge history; force snd_din 8'hFF, snd_nmi_n 1; keep cmd latch, cmd_pend, reply latch and all main-side behaviour.
REQ-032 SHALL give rst priority over snd_rst and over any coincident access event.

Verification
REQ-033 SHALL cover: rst, sound writes addr 1, main writes 8'h5A to addr 0 holding cs 20 cycles -> cmd_pend=1 once, snd_nmi_n low 2 cycles after edge, sound read addr 0 returns 8'h5A, snd_nmi_n high one cycle after read event.
REQ-034 SHALL cover: sound writes 8'hC3 addr 0 -> main read addr 1 returns 8'h02; main read addr 0 returns 8'hC3; next addr 1 read returns 8'h00.
REQ-035 SHALL cover: main write 8'h11 event in same cycle as sound read event of addr 0 -> cmd_pend=1, cmd latch 8'h11.
REQ-036 SHALL cover: nmi_en=0, main write 8'h22 -> snd_nmi_n stays 1; sound writes addr 1 -> snd_nmi_n falls next-but-one cycle; sound writes addr 2 -> snd_nmi_n returns 1.
REQ-037 SHALL cover: cmd_pend=1, rep_pend=1, nmi_en=1, pulse snd_rst 3 cycles -> cmd_pend 1, rep_pend 0, nmi_en 0, snd_nmi_n 1; main addr 1 read returns 8'h01.
REQ-038 SHALL cover: reads of addr 2/3 both sides return 8'hFF; cs low returns 8'hFF; writes to addr 3 change no state.
